// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg
// Shared types and constants for the serial frame transmitter:
//   - tx_state_t : frame sequencing states
//   - LINE_*     : serial line levels for idle, start and stop bits
//   - idx_width  : width of the data bit index for a given data width
package serial_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_STOP  = 1'b1;
    localparam logic LINE_START = 1'b0;

    // Bit index must hold 0..data_width-1.
    function automatic int idx_width(input int data_width);
        return (data_width <= 2) ? 1 : $clog2(data_width);
    endfunction

endpackage

// File: rtl/serial_tx_shift_reg.sv
// serial_tx_shift_reg
// Loadable right-shift register feeding the serial line LSB-first.
// Build option: SERIAL_TX_PARITY_EN adds a registered even-parity output
// computed from the loaded word (not from the shifting contents).
// Ports:
//   clk       : clock, registers update on its falling edge
//   rst       : asynchronous active-high reset
//   load      : capture load_data
//   shift     : shift right by one, zero fill at the top
//   load_data : word to capture
//   parity    : XOR of the captured word (only with SERIAL_TX_PARITY_EN)
//   bit0      : current LSB, the next data bit to send
module serial_tx_shift_reg
    import serial_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  shift,
    input  logic [DATA_WIDTH-1:0] load_data,
`ifdef SERIAL_TX_PARITY_EN
    output logic                  parity,
`endif
    output logic                  bit0
);

    logic [DATA_WIDTH-1:0] sr;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else if (load) begin
            sr <= load_data;
        end else if (shift) begin
            sr <= {1'b0, sr[DATA_WIDTH-1:1]};
        end
    end

`ifdef SERIAL_TX_PARITY_EN
    // Latched at capture so it is unaffected by the shifting.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            parity <= 1'b0;
        end else if (load) begin
            parity <= ^load_data;
        end
    end
`endif

    assign bit0 = sr[0];

endmodule

// File: rtl/serial_frame_transmitter.sv
// serial_frame_transmitter
// Parallel-to-serial framed transmitter: start bit (0), DATA_WIDTH data bits
// LSB-first, optional even-parity bit, STOP_BITS stop bits (1). All outputs
// are registered and change on the falling edge of Clk_In.
// Build option: SERIAL_TX_PARITY_EN inserts the even-parity bit after the
// last data bit; without it DATA goes straight to STOP.
// Ports:
//   Clk_In           : clock, falling-edge active
//   Reset_In         : asynchronous active-high reset
//   Parallel_Data_In : word to transmit, sampled on handshake
//   Load_Valid_In    : producer offers a word
//   Load_Ready_Out   : high only in IDLE
//   Serial_Data_Out  : serial line, idle high
//   Frame_Active_Out : high start bit through last stop bit
//   Frame_Done_Out   : one-cycle pulse in the first IDLE cycle after a frame
//
// state  | meaning
// IDLE   | line high, ready for a word
// START  | start bit on the line
// DATA   | data bit bit_idx on the line
// PARITY | even-parity bit on the line
// STOP   | stop bit(s) on the line, stop_cnt counts down
module serial_frame_transmitter
    import serial_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                  Clk_In,
    input  logic                  Reset_In,
    input  logic [DATA_WIDTH-1:0] Parallel_Data_In,
    input  logic                  Load_Valid_In,
    output logic                  Load_Ready_Out,
    output logic                  Serial_Data_Out,
    output logic                  Frame_Active_Out,
    output logic                  Frame_Done_Out
);

    localparam int IDX_W = idx_width(DATA_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);
    localparam logic STOP_LOAD = 1'(STOP_BITS - 1);

    tx_state_t        state;
    logic [IDX_W-1:0] bit_idx;
    logic             stop_cnt;
    logic             sr_load;
    logic             sr_shift;
    logic             sr_bit0;
`ifdef SERIAL_TX_PARITY_EN
    logic             sr_parity;
`endif

    assign sr_load  = (state == IDLE) && Load_Valid_In;
    // Shift on the edge that puts the current LSB on the line, so bit0
    // already holds the following bit for the next edge.
    assign sr_shift = (state == START) || ((state == DATA) && (bit_idx != LAST_IDX));

    serial_tx_shift_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shift_reg (
        .clk       (Clk_In),
        .rst       (Reset_In),
        .load      (sr_load),
        .shift     (sr_shift),
        .load_data (Parallel_Data_In),
`ifdef SERIAL_TX_PARITY_EN
        .parity    (sr_parity),
`endif
        .bit0      (sr_bit0)
    );

    always_ff @(negedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            state            <= IDLE;
            bit_idx          <= '0;
            stop_cnt         <= 1'b0;
            Serial_Data_Out  <= LINE_IDLE;
            Load_Ready_Out   <= 1'b1;
            Frame_Active_Out <= 1'b0;
            Frame_Done_Out   <= 1'b0;
        end else begin
            Frame_Done_Out <= 1'b0;
            case (state)
                IDLE: begin
                    if (Load_Valid_In) begin
                        state            <= START;
                        Serial_Data_Out  <= LINE_START;
                        Load_Ready_Out   <= 1'b0;
                        Frame_Active_Out <= 1'b1;
                    end
                end
                START: begin
                    state           <= DATA;
                    bit_idx         <= '0;
                    Serial_Data_Out <= sr_bit0;
                end
                DATA: begin
                    if (bit_idx == LAST_IDX) begin
`ifdef SERIAL_TX_PARITY_EN
                        state           <= PARITY;
                        Serial_Data_Out <= sr_parity;
`else
                        state           <= STOP;
                        Serial_Data_Out <= LINE_STOP;
                        stop_cnt        <= STOP_LOAD;
`endif
                    end else begin
                        bit_idx         <= bit_idx + 1'b1;
                        Serial_Data_Out <= sr_bit0;
                    end
                end
                PARITY: begin
                    state           <= STOP;
                    Serial_Data_Out <= LINE_STOP;
                    stop_cnt        <= STOP_LOAD;
                end
                STOP: begin
                    if (stop_cnt == 1'b0) begin
                        state            <= IDLE;
                        Serial_Data_Out  <= LINE_IDLE;
                        Load_Ready_Out   <= 1'b1;
                        Frame_Active_Out <= 1'b0;
                        Frame_Done_Out   <= 1'b1;
                    end else begin
                        stop_cnt <= stop_cnt - 1'b1;
                    end
                end
                default: begin
                    state            <= IDLE;
                    Serial_Data_Out  <= LINE_IDLE;
                    Load_Ready_Out   <= 1'b1;
                    Frame_Active_Out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_transmitter.sv
// tb_serial_frame_transmitter
// Drives two transmitters (STOP_BITS=1 and STOP_BITS=2) with identical
// inputs and compares every output each cycle against a queue-based frame
// model: an accepted word becomes a list of line levels that is consumed one
// per cycle. Honours SERIAL_TX_PARITY_EN.
module tb_serial_frame_transmitter;

    localparam int DW = 8;
`ifdef SERIAL_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic          clk = 1'b1;
    logic          rst;
    logic [DW-1:0] data;
    logic          valid;
    logic          line_o   [2];
    logic          ready_o  [2];
    logic          active_o [2];
    logic          done_o   [2];

    int n_vec = 0;
    int n_err = 0;

    serial_frame_transmitter #(.DATA_WIDTH(DW), .STOP_BITS(1)) dut_s1 (
        .Clk_In           (clk),
        .Reset_In         (rst),
        .Parallel_Data_In (data),
        .Load_Valid_In    (valid),
        .Load_Ready_Out   (ready_o[0]),
        .Serial_Data_Out  (line_o[0]),
        .Frame_Active_Out (active_o[0]),
        .Frame_Done_Out   (done_o[0])
    );

    serial_frame_transmitter #(.DATA_WIDTH(DW), .STOP_BITS(2)) dut_s2 (
        .Clk_In           (clk),
        .Reset_In         (rst),
        .Parallel_Data_In (data),
        .Load_Valid_In    (valid),
        .Load_Ready_Out   (ready_o[1]),
        .Serial_Data_Out  (line_o[1]),
        .Frame_Active_Out (active_o[1]),
        .Frame_Done_Out   (done_o[1])
    );

    always #5 clk = ~clk;

    // Reference model: queue of line levels still to be shown; front is
    // what the line carries in the current cycle.
    bit   mq [2][$];
    logic exp_line [2], exp_ready [2], exp_active [2], exp_done [2];

    always @(negedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                mq[k].delete();
                exp_done[k] = 1'b0;
            end else if (mq[k].size() > 0) begin
                void'(mq[k].pop_front());
                exp_done[k] = (mq[k].size() == 0);
            end else begin
                exp_done[k] = 1'b0;
                if (valid) begin
                    mq[k].push_back(1'b0);
                    for (int i = 0; i < DW; i++) mq[k].push_back(data[i]);
                    if (P == 1) mq[k].push_back(^data);
                    for (int s = 0; s <= k; s++) mq[k].push_back(1'b1);
                end
            end
            exp_line[k]   = (mq[k].size() > 0) ? mq[k][0] : 1'b1;
            exp_ready[k]  = (mq[k].size() == 0);
            exp_active[k] = (mq[k].size() > 0);
        end
    end

    task automatic test_reset();
        rst = 1'b1; valid = 1'b0; data = '0;
        repeat (3) @(posedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if ({line_o[k], ready_o[k], active_o[k], done_o[k]} !== 4'b1100) begin
                    n_err++;
                    $display("FAIL reset_idle inst%0d got line/rdy/act/done=%b%b%b%b want 1100",
                             k, line_o[k], ready_o[k], active_o[k], done_o[k]);
                end
            end
        end
    endtask

    task automatic test_known_words();
        logic [DW-1:0] words [4] = '{8'hA5, 8'h07, 8'hFF, 8'h55};
        int act_cnt [2];
        int done_cnt [2];
        int zero_cnt [2];
        int exp_zero;
        for (int w = 0; w < 4; w++) begin
            for (int k = 0; k < 2; k++) begin
                act_cnt[k] = 0; done_cnt[k] = 0; zero_cnt[k] = 0;
            end
            @(posedge clk);
            data = words[w]; valid = 1'b1;
            for (int c = 0; c < 16; c++) begin
                @(posedge clk);
                valid = 1'b0;
                data  = DW'($urandom);
                for (int k = 0; k < 2; k++) begin
                    n_vec++;
                    if ({line_o[k], ready_o[k], active_o[k], done_o[k]} !==
                        {exp_line[k], exp_ready[k], exp_active[k], exp_done[k]}) begin
                        n_err++;
                        $display("FAIL word_%h inst%0d cyc%0d got %b%b%b%b want %b%b%b%b",
                                 words[w], k, c, line_o[k], ready_o[k], active_o[k], done_o[k],
                                 exp_line[k], exp_ready[k], exp_active[k], exp_done[k]);
                    end
                    if (active_o[k] === 1'b1) act_cnt[k]++;
                    if (active_o[k] === 1'b1 && line_o[k] === 1'b0) zero_cnt[k]++;
                    if (done_o[k] === 1'b1) done_cnt[k]++;
                end
            end
            exp_zero = 1 + (DW - $countones(words[w])) + ((P == 1 && (^words[w]) == 1'b0) ? 1 : 0);
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if (act_cnt[k] != 1 + DW + P + k + 1 || done_cnt[k] != 1 || zero_cnt[k] != exp_zero) begin
                    n_err++;
                    $display("FAIL frame_shape_%h inst%0d got act/done/zeros=%0d/%0d/%0d want %0d/1/%0d",
                             words[w], k, act_cnt[k], done_cnt[k], zero_cnt[k], 1 + DW + P + k + 1, exp_zero);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic prev_done [2] = '{1'b0, 1'b0};
        @(posedge clk);
        data = 8'h3C; valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if ({line_o[k], ready_o[k], active_o[k], done_o[k]} !==
                    {exp_line[k], exp_ready[k], exp_active[k], exp_done[k]}) begin
                    n_err++;
                    $display("FAIL back_to_back inst%0d cyc%0d got %b%b%b%b want %b%b%b%b",
                             k, c, line_o[k], ready_o[k], active_o[k], done_o[k],
                             exp_line[k], exp_ready[k], exp_active[k], exp_done[k]);
                end
                if (prev_done[k]) begin
                    n_vec++;
                    if (line_o[k] !== 1'b0 || active_o[k] !== 1'b1) begin
                        n_err++;
                        $display("FAIL restart_after_done inst%0d got line=%b act=%b want line=0 act=1",
                                 k, line_o[k], active_o[k]);
                    end
                end
                prev_done[k] = done_o[k];
            end
            data = (c == 0) ? 8'hC3 : ((c < 12) ? DW'($urandom) : 8'hC3);
        end
        valid = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if ({line_o[k], ready_o[k], active_o[k], done_o[k]} !==
                    {exp_line[k], exp_ready[k], exp_active[k], exp_done[k]}) begin
                    n_err++;
                    $display("FAIL b2b_drain inst%0d cyc%0d got %b%b%b%b want %b%b%b%b",
                             k, c, line_o[k], ready_o[k], active_o[k], done_o[k],
                             exp_line[k], exp_ready[k], exp_active[k], exp_done[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        @(posedge clk);
        data = 8'h55; valid = 1'b1;
        // cycle 0 is the start bit, cycle 5 carries data bit 4
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            valid = 1'b0;
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if ({line_o[k], ready_o[k], active_o[k], done_o[k]} !==
                    {exp_line[k], exp_ready[k], exp_active[k], exp_done[k]}) begin
                    n_err++;
                    $display("FAIL pre_abort inst%0d cyc%0d got %b%b%b%b want %b%b%b%b",
                             k, c, line_o[k], ready_o[k], active_o[k], done_o[k],
                             exp_line[k], exp_ready[k], exp_active[k], exp_done[k]);
                end
            end
        end
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if ({line_o[k], ready_o[k], active_o[k], done_o[k]} !== 4'b1100) begin
                n_err++;
                $display("FAIL async_abort inst%0d got line/rdy/act/done=%b%b%b%b want 1100",
                         k, line_o[k], ready_o[k], active_o[k], done_o[k]);
            end
        end
        @(posedge clk);
        rst = 1'b0;
        for (int c = 0; c < 35; c++) begin
            @(posedge clk);
            valid = (c == 4);
            data  = (c == 4) ? 8'h55 : DW'($urandom);
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if ({line_o[k], ready_o[k], active_o[k], done_o[k]} !==
                    {exp_line[k], exp_ready[k], exp_active[k], exp_done[k]}) begin
                    n_err++;
                    $display("FAIL post_abort inst%0d cyc%0d got %b%b%b%b want %b%b%b%b",
                             k, c, line_o[k], ready_o[k], active_o[k], done_o[k],
                             exp_line[k], exp_ready[k], exp_active[k], exp_done[k]);
                end
            end
        end
        valid = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if ({line_o[k], ready_o[k], active_o[k], done_o[k]} !==
                    {exp_line[k], exp_ready[k], exp_active[k], exp_done[k]}) begin
                    n_err++;
                    $display("FAIL random inst%0d cyc%0d got %b%b%b%b want %b%b%b%b",
                             k, c, line_o[k], ready_o[k], active_o[k], done_o[k],
                             exp_line[k], exp_ready[k], exp_active[k], exp_done[k]);
                end
            end
            valid = ($urandom_range(0, 2) == 0);
            data  = DW'($urandom);
        end
        valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_known_words();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
